sha256_loader: RTL and testbench

Front-end stage for `sha256_core`. It accepts a byte-serial message over a valid/ready stream and applies SHA-256 single-block padding. It drives the core's byte-wide write bus to load the 64-byte block, starts the core and waits for its completion interrupt. It then reads the 32-byte digest back through the core's read mux and emits it as a byte stream, so the rest of the design never touches the core's register map.

---
 rtl/sha256_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_sha256_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_loader.sv
// sha256_loader
//
// Front end for sha256_core. Takes a byte-serial message (1..55 bytes) on a
// valid/ready stream, applies single-block SHA-256 padding while loading the
// 64-byte block into the core over its byte-wide write bus, starts the core,
// waits for its completion pulse, then reads the 32-byte digest back through
// the core read mux and emits it as a byte stream.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid/i_data/i_last   message byte stream in, o_ready back-pressure
//   o_w_addr/o_data8/o_we   core address (write and read), write data, write enable
//   i_irq                   core completion pulse
//   i_core_data             core read-mux data (combinational from o_w_addr)
//   o_digest_valid/_byte/_last, i_digest_ready   digest byte stream out
//   o_busy                  high whenever not idle
//   o_err                   one-cycle pulse after an over-length message is drained
module sha256_loader #(
    parameter int STATUS_ADDR     = 65,
    parameter int DIGEST_TOP_ADDR = 101
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic       o_ready,
    output logic [6:0] o_w_addr,
    output logic [7:0] o_data8,
    output logic       o_we,
    input  logic       i_irq,
    input  logic [7:0] i_core_data,
    output logic       o_digest_valid,
    output logic [7:0] o_digest_byte,
    output logic       o_digest_last,
    input  logic       i_digest_ready,
    output logic       o_busy,
    output logic       o_err
);

    localparam logic [6:0] STATUS_A  = 7'(STATUS_ADDR);
    localparam logic [6:0] DIG_TOP_A = 7'(DIGEST_TOP_ADDR);
    localparam logic [5:0] MAX_LEN   = 6'd55;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_PAD, S_START, S_WAIT, S_READ
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;            // bytes accepted so far
    logic [5:0] len_q, len_d;            // message length L, latched on i_last
    logic [5:0] pad_addr_q, pad_addr_d;  // next padding address, counts down to 0
    logic [4:0] j_q, j_d;                // digest byte index
    logic [6:0] w_addr_q, w_addr_d;
    logic [7:0] data8_q, data8_d;
    logic       we_q, we_d;
    logic       err_q, err_d;

    logic       accept;
    logic [7:0] pad_byte;
    logic [4:0] j_inc;

    assign o_ready = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign accept  = i_valid & o_ready;
    assign j_inc   = j_q + 5'd1;

    // Padding content for the current pad address: 0x80 marker right after the
    // message, then zeros, with the 16 LSBs of the bit length (L*8) in
    // addresses 1 and 0. L <= 55 keeps L*8 below 512, so only bit 8 can be set
    // in the upper length byte.
    always_comb begin
        pad_byte = 8'h00;
        if (pad_addr_q == (6'd63 - len_q)) begin
            pad_byte = 8'h80;
        end else if (pad_addr_q == 6'd1) begin
            pad_byte = {7'd0, len_q[5]};
        end else if (pad_addr_q == 6'd0) begin
            pad_byte = {len_q[4:0], 3'b000};
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    // A 56th byte means the message cannot fit one block.
                    if (cnt_q == MAX_LEN) begin
                        state_d = i_last ? S_IDLE : S_DRAIN;
                    end else if (i_last) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && i_last) begin
                    state_d = S_IDLE;
                end
            end
            S_PAD: begin
                if (pad_addr_q == 6'd0) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (i_irq) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (i_digest_ready && (j_q == 5'd31)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        pad_addr_d = pad_addr_q;
        j_d        = j_q;
        w_addr_d   = w_addr_q;
        data8_d    = data8_q;
        we_d       = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (cnt_q == MAX_LEN) begin
                        // Over-length: stop writing, drain the rest.
                        if (i_last) begin
                            err_d = 1'b1;
                            cnt_d = 6'd0;
                        end
                    end else begin
                        // Message byte k lands at address 63-k (byte 0 is the
                        // most significant byte of W0).
                        w_addr_d = {1'b0, 6'd63 - cnt_q};
                        data8_d  = i_data;
                        we_d     = 1'b1;
                        cnt_d    = cnt_q + 6'd1;
                        if (i_last) begin
                            len_d      = cnt_q + 6'd1;
                            pad_addr_d = 6'd62 - cnt_q;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (accept && i_last) begin
                    err_d = 1'b1;
                    cnt_d = 6'd0;
                end
            end
            S_PAD: begin
                w_addr_d = {1'b0, pad_addr_q};
                data8_d  = pad_byte;
                we_d     = 1'b1;
                if (pad_addr_q != 6'd0) begin
                    pad_addr_d = pad_addr_q - 6'd1;
                end
            end
            S_START: begin
                w_addr_d = STATUS_A;
                data8_d  = 8'h01;
                we_d     = 1'b1;
                j_d      = 5'd0;
            end
            S_WAIT: begin
                // Pre-point the read mux at digest byte 0 so it is ready the
                // cycle READ is entered.
                w_addr_d = DIG_TOP_A;
                j_d      = 5'd0;
            end
            S_READ: begin
                if (i_digest_ready) begin
                    j_d      = j_inc;
                    w_addr_d = DIG_TOP_A - {2'b00, j_inc};
                    if (j_q == 5'd31) begin
                        cnt_d = 6'd0;
                    end
                end
            end
            default: begin
                cnt_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= 6'd0;
            len_q      <= 6'd0;
            pad_addr_q <= 6'd0;
            j_q        <= 5'd0;
            w_addr_q   <= 7'd0;
            data8_q    <= 8'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            pad_addr_q <= pad_addr_d;
            j_q        <= j_d;
            w_addr_q   <= w_addr_d;
            data8_q    <= data8_d;
            we_q       <= we_d;
            err_q      <= err_d;
        end
    end

    assign o_w_addr       = w_addr_q;
    assign o_data8        = data8_q;
    assign o_we           = we_q;
    assign o_err          = err_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_digest_valid = (state_q == S_READ);
    assign o_digest_byte  = o_digest_valid ? i_core_data : 8'h00;
    assign o_digest_last  = o_digest_valid && (j_q == 5'd31);

endmodule

// File: tb/tb_sha256_loader.sv
// Testbench for sha256_loader. Contains a behavioural sha256_core stand-in
// (64-byte register file, status start, delayed irq, digest read mux) and a
// reference model that pads the message and hashes it directly.
module tb_sha256_loader;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_last;
    logic       o_ready;
    logic [6:0] o_w_addr;
    logic [7:0] o_data8;
    logic       o_we;
    logic       i_irq;
    logic [7:0] i_core_data;
    logic       o_digest_valid;
    logic [7:0] o_digest_byte;
    logic       o_digest_last;
    logic       i_digest_ready;
    logic       o_busy;
    logic       o_err;

    always #5 i_clk = ~i_clk;

    sha256_loader #(.STATUS_ADDR(65), .DIGEST_TOP_ADDR(101)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .i_data(i_data), .i_last(i_last), .o_ready(o_ready),
        .o_w_addr(o_w_addr), .o_data8(o_data8), .o_we(o_we),
        .i_irq(i_irq), .i_core_data(i_core_data),
        .o_digest_valid(o_digest_valid), .o_digest_byte(o_digest_byte),
        .o_digest_last(o_digest_last), .i_digest_ready(i_digest_ready),
        .o_busy(o_busy), .o_err(o_err)
    );

    // ---------------- SHA-256 reference ----------------
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] H_INIT =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256_compress(input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = H_INIT;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + H_INIT[255:224], b + H_INIT[223:192], c + H_INIT[191:160], d + H_INIT[159:128],
                e + H_INIT[127:96],  f + H_INIT[95:64],   g + H_INIT[63:32],   h + H_INIT[31:0]};
    endfunction

    // ---------------- core stand-in ----------------
    logic [7:0]   mem [128];
    logic [255:0] dig_q;
    int           countdown;

    function automatic logic [511:0] mem_block();
        logic [511:0] blk;
        for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = mem[63 - i];
        return blk;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            countdown <= 0;
            i_irq     <= 1'b0;
        end else begin
            i_irq <= 1'b0;
            if (o_we) begin
                mem[o_w_addr] <= o_data8;
                if (o_w_addr == 7'd65 && o_data8 == 8'h01) countdown <= 20;
            end
            if (countdown > 0) begin
                countdown <= countdown - 1;
                if (countdown == 1) begin
                    dig_q <= sha256_compress(mem_block());
                    i_irq <= 1'b1;
                end
            end
        end
    end

    assign i_core_data = (o_w_addr >= 7'd70 && o_w_addr <= 7'd101) ?
                         dig_q[8*(o_w_addr - 7'd70) +: 8] : mem[o_w_addr];

    // ---------------- monitors ----------------
    logic [14:0] wr_q [$];   // {addr, data} of every core write
    int          err_cnt = 0;

    always @(negedge i_clk) begin
        if (i_rst_n && o_we) wr_q.push_back({o_w_addr, o_data8});
        if (o_err) err_cnt <= err_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 256'(o_ready), 256'(1));
        chk({tag, "_addr"},  256'(o_w_addr), 256'(0));
        chk({tag, "_data8"}, 256'(o_data8), 256'(0));
        chk({tag, "_we"},    256'(o_we), 256'(0));
        chk({tag, "_dvalid"}, 256'(o_digest_valid), 256'(0));
        chk({tag, "_dbyte"}, 256'(o_digest_byte), 256'(0));
        chk({tag, "_dlast"}, 256'(o_digest_last), 256'(0));
        chk({tag, "_busy"},  256'(o_busy), 256'(0));
        chk({tag, "_err"},   256'(o_err), 256'(0));
    endtask

    logic [7:0] msg_q [$];

    // Padded block in message order, built straight from the padding rule.
    function automatic logic [511:0] ref_block();
        logic [511:0] blk = '0;
        int L = msg_q.size();
        for (int i = 0; i < L; i++) blk[511 - 8*i -: 8] = msg_q[i];
        blk[511 - 8*L -: 8] = 8'h80;
        blk[63:0] = 64'(L * 8);
        return blk;
    endfunction

    task automatic build_msg(input int len, input int fill);
        msg_q.delete();
        if (fill == -2) begin
            msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        end else begin
            for (int i = 0; i < len; i++)
                msg_q.push_back(fill < 0 ? 8'($urandom_range(0, 255)) : 8'(fill));
        end
    endtask

    task automatic send_msg(input int gap, input bit exp_err);
        int  tmo;
        bit  acc;
        for (int k = 0; k < msg_q.size(); k++) begin
            for (int g = 0; g < gap; g++) begin
                i_valid = 1'b0;
                @(posedge i_clk); #1;
            end
            i_valid = 1'b1;
            i_data  = msg_q[k];
            i_last  = (k == msg_q.size() - 1);
            tmo = 0;
            do begin
                @(negedge i_clk);
                acc = o_ready;
                @(posedge i_clk); #1;
                tmo++;
            end while (!acc && tmo < 200);
            if (!acc) chk("accept_timeout", 256'(acc), 256'(1));
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (exp_err) begin
            chk("err_pulse", 256'(o_err), 256'(1));
            chk("busy_after_err", 256'(o_busy), 256'(0));
            @(posedge i_clk); #1;
            chk("err_width", 256'(o_err), 256'(0));
        end else begin
            chk("ready_after_last", 256'(o_ready), 256'(0));
            chk("busy_after_last", 256'(o_busy), 256'(1));
        end
    endtask

    task automatic finish_msg(input int id, input bit bp, input bit exp_err,
                              input int exp_writes, input bit is_abc,
                              input int wr_base, input int err_base);
        logic [511:0] blk = ref_block();
        logic [255:0] dig = '0;
        int got = 0;
        int cyc = 0;
        int nw;
        if (!exp_err) begin
            while (got < 32 && cyc < 3000) begin
                @(negedge i_clk);
                cyc++;
                i_digest_ready = bp ? ~i_digest_ready : 1'b1;
                if (o_digest_valid) begin
                    chk("rd_addr", 256'(o_w_addr), 256'(101 - got));
                    chk("we_in_read", 256'(o_we), 256'(0));
                    if (i_digest_ready) begin
                        chk("last_flag", 256'(o_digest_last), 256'(got == 31));
                        dig[255 - 8*got -: 8] = o_digest_byte;
                        got++;
                    end
                end
            end
            chk("digest_count", 256'(got), 256'(32));
            chk("digest", dig, sha256_compress(blk));
            if (is_abc) chk("abc_digest", dig, ABC_DIGEST);
            @(posedge i_clk); #1;
        end else begin
            repeat (5) @(posedge i_clk);
            #1;
            chk("err_count", 256'(err_cnt - err_base), 256'(1));
        end
        chk("idle_busy", 256'(o_busy), 256'(0));
        chk("idle_ready", 256'(o_ready), 256'(1));
        nw = wr_q.size() - wr_base;
        chk("wr_count", 256'(nw), 256'(exp_writes));
        for (int i = 0; i < nw && i < exp_writes; i++) begin
            if (i < 64)
                chk("wr_entry", 256'(wr_q[wr_base + i]), 256'({7'(63 - i), blk[511 - 8*i -: 8]}));
            else
                chk("wr_start", 256'(wr_q[wr_base + i]), 256'({7'd65, 8'h01}));
        end
        $display("msg %0d len=%0d bp=%0d err=%0d writes=%0d digest=%h",
                 id, msg_q.size(), bp, exp_err, nw, dig);
    endtask

    task automatic run_msg(input int id, input int len, input int fill, input int gap,
                           input bit bp, input bit exp_err, input int exp_writes);
        int wr_base;
        int err_base;
        build_msg(len, fill);
        wr_base  = wr_q.size();
        err_base = err_cnt;
        send_msg(gap, exp_err);
        finish_msg(id, bp, exp_err, exp_writes, fill == -2, wr_base, err_base);
    endtask

    typedef struct {
        int len;        // message length
        int fill;       // byte value, -1 random, -2 "abc"
        int gap;        // idle cycles before each byte
        bit bp;         // toggle i_digest_ready during READ
        bit exp_err;    // over-length message expected
        int exp_writes; // expected number of core writes
    } vec_t;

    vec_t tbl [9];

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0; i_digest_ready = 1'b1;

        tbl[0] = '{3,  -2,    0, 1'b0, 1'b0, 65};
        tbl[1] = '{55, 8'h41, 0, 1'b0, 1'b0, 65};
        tbl[2] = '{56, 8'h41, 0, 1'b0, 1'b1, 55};
        tbl[3] = '{3,  -2,    0, 1'b1, 1'b0, 65};
        tbl[4] = '{3,  -2,    3, 1'b0, 1'b0, 65};
        tbl[5] = '{1,  -1,    0, 1'b0, 1'b0, 65};
        tbl[6] = '{54, -1,    0, 1'b1, 1'b0, 65};
        tbl[7] = '{60, -1,    1, 1'b0, 1'b1, 55};
        tbl[8] = '{32, -1,    1, 1'b1, 1'b0, 65};

        #2;
        chk_reset_outputs("reset");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 9; i++)
            run_msg(i, tbl[i].len, tbl[i].fill, tbl[i].gap, tbl[i].bp,
                    tbl[i].exp_err, tbl[i].exp_writes);

        // Reset while waiting for the core, then a clean "abc".
        begin
            bit seen = 1'b0;
            build_msg(3, -2);
            send_msg(0, 1'b0);
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge i_clk);
                if (o_we && o_w_addr == 7'd65) seen = 1'b1;
            end
            chk("start_seen", 256'(seen), 256'(1));
            @(posedge i_clk); #3;
            i_rst_n = 1'b0;
            #1;
            chk_reset_outputs("midwait");
            @(negedge i_clk);
            i_rst_n = 1'b1;
            @(posedge i_clk); #1;
            $display("msg reset-mid-wait applied");
            run_msg(100, 3, -2, 0, 1'b0, 1'b0, 65);
        end

        for (int r = 0; r < 10; r++) begin
            int  len = $urandom_range(1, 62);
            bit  e   = (len > 55);
            run_msg(200 + r, len, -1, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    e, e ? 55 : 65);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
